// File: rtl/user_obi_demux.sv
// user_obi_demux
//   OBI subordinate-side demultiplexer. Each request address is decoded
//   against a runtime address map and forwarded to one of NumPorts manager
//   ports; unmapped addresses go to a built-in error responder. Outstanding
//   transactions are all held to a single target, so responses return in
//   request order without reordering logic.
//
// Ports (OBI structs are flattened into one port per field):
//   clk_i, rst_ni         clock, asynchronous active-low reset
//   addr_map_*_i          NumRules rules {idx, start (inclusive), end (exclusive)}
//   sbr_req_*_i           upstream a-channel: req, we, be, addr, wdata, aid
//   sbr_rsp_*_o           upstream response: gnt, rvalid, rdata, rid, err
//   mgr_req_*_o           per-port a-channel (broadcast), per-port req bit
//   mgr_rsp_*_i           per-port response: gnt, rvalid, rdata, rid, err
//   busy_o                high while any transaction is outstanding
//   err_irq_o             one-cycle pulse alongside each error response
//   err_addr_o            address of the most recent decode error
module user_obi_demux #(
    parameter int unsigned NumPorts    = 2,
    parameter int unsigned NumRules    = 2,
    parameter int unsigned NumMaxTrans = 2,
    parameter logic [31:0] ErrData     = 32'hBADCAB1E,
    parameter int unsigned IdWidth     = 4,
    // Derived widths; leave at their defaults.
    parameter int unsigned TgtWidth    = $clog2(NumPorts + 1),
    parameter int unsigned CntWidth    = $clog2(NumMaxTrans + 1)
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic [NumRules-1:0][TgtWidth-1:0]    addr_map_idx_i,
    input  logic [NumRules-1:0][31:0]            addr_map_start_i,
    input  logic [NumRules-1:0][31:0]            addr_map_end_i,
    input  logic                                 sbr_req_req_i,
    input  logic                                 sbr_req_we_i,
    input  logic [3:0]                           sbr_req_be_i,
    input  logic [31:0]                          sbr_req_addr_i,
    input  logic [31:0]                          sbr_req_wdata_i,
    input  logic [IdWidth-1:0]                   sbr_req_aid_i,
    output logic                                 sbr_rsp_gnt_o,
    output logic                                 sbr_rsp_rvalid_o,
    output logic [31:0]                          sbr_rsp_rdata_o,
    output logic [IdWidth-1:0]                   sbr_rsp_rid_o,
    output logic                                 sbr_rsp_err_o,
    output logic [NumPorts-1:0]                  mgr_req_req_o,
    output logic [NumPorts-1:0]                  mgr_req_we_o,
    output logic [NumPorts-1:0][3:0]             mgr_req_be_o,
    output logic [NumPorts-1:0][31:0]            mgr_req_addr_o,
    output logic [NumPorts-1:0][31:0]            mgr_req_wdata_o,
    output logic [NumPorts-1:0][IdWidth-1:0]     mgr_req_aid_o,
    input  logic [NumPorts-1:0]                  mgr_rsp_gnt_i,
    input  logic [NumPorts-1:0]                  mgr_rsp_rvalid_i,
    input  logic [NumPorts-1:0][31:0]            mgr_rsp_rdata_i,
    input  logic [NumPorts-1:0][IdWidth-1:0]     mgr_rsp_rid_i,
    input  logic [NumPorts-1:0]                  mgr_rsp_err_i,
    output logic                                 busy_o,
    output logic                                 err_irq_o,
    output logic [31:0]                          err_addr_o
);

    // The error responder is addressed as one extra port past the last real one.
    localparam logic [TgtWidth-1:0] ErrTgt = TgtWidth'(NumPorts);
    localparam logic [CntWidth-1:0] CntMax = CntWidth'(NumMaxTrans);

    logic [CntWidth-1:0] cnt_q;
    logic [TgtWidth-1:0] locked_q;
    logic                err_valid_q;
    logic [IdWidth-1:0]  err_rid_q;
    logic [31:0]         err_addr_q;

    logic [TgtWidth-1:0] target;
    logic                tgt_is_err;
    logic                tgt_gnt;
    logic                stall;
    logic                handshake;
    logic                rsp_fire;
    logic                sel_rvalid;
    logic [31:0]         sel_rdata;
    logic [IdWidth-1:0]  sel_rid;
    logic                sel_err;

    // Address decode. Rules are scanned from the highest index down so the
    // lowest-numbered match is the one left standing. Rule indices that do
    // not name a real port fall through to the error responder.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        target = ErrTgt;
        for (int r = int'(NumRules) - 1; r >= 0; r--) begin
            if ((sbr_req_addr_i >= addr_map_start_i[r]) &&
                (sbr_req_addr_i <  addr_map_end_i[r])) begin
                target = (addr_map_idx_i[r] < ErrTgt) ? addr_map_idx_i[r] : ErrTgt;
            end
        end
    end

    assign tgt_is_err = (target == ErrTgt);

    // Holding every outstanding transaction to one target keeps responses in
    // order; the count limit bounds the error responder's aid storage.
    assign stall = (cnt_q == CntMax) || ((cnt_q != '0) && (target != locked_q));

    always_comb begin
        tgt_gnt = tgt_is_err;
        for (int p = 0; p < int'(NumPorts); p++) begin
            if (target == TgtWidth'(p)) begin
                tgt_gnt = mgr_rsp_gnt_i[p];
            end
        end
    end

    // gnt is qualified with req so the upstream response is all-zero when idle.
    assign sbr_rsp_gnt_o = sbr_req_req_i & tgt_gnt & ~stall;
    assign handshake     = sbr_req_req_i & sbr_rsp_gnt_o;

    // The a-channel is broadcast; only the targeted port sees req.
    always_comb begin
        for (int p = 0; p < int'(NumPorts); p++) begin
            mgr_req_req_o[p]   = sbr_req_req_i & ~stall & (target == TgtWidth'(p));
            mgr_req_we_o[p]    = sbr_req_we_i;
            mgr_req_be_o[p]    = sbr_req_be_i;
            mgr_req_addr_o[p]  = sbr_req_addr_i;
            mgr_req_wdata_o[p] = sbr_req_wdata_i;
            mgr_req_aid_o[p]   = sbr_req_aid_i;
        end
    end

    // Response mux follows the locked target; other ports' rvalid is ignored.
    always_comb begin
        sel_rvalid = 1'b0;
        sel_rdata  = '0;
        sel_rid    = '0;
        sel_err    = 1'b0;
        if (locked_q == ErrTgt) begin
            sel_rvalid = err_valid_q;
            sel_rdata  = ErrData;
            sel_rid    = err_rid_q;
            sel_err    = 1'b1;
        end else begin
            for (int p = 0; p < int'(NumPorts); p++) begin
                if (locked_q == TgtWidth'(p)) begin
                    sel_rvalid = mgr_rsp_rvalid_i[p];
                    sel_rdata  = mgr_rsp_rdata_i[p];
                    sel_rid    = mgr_rsp_rid_i[p];
                    sel_err    = mgr_rsp_err_i[p];
                end
            end
        end
    end

    // With nothing outstanding a port rvalid is stale (e.g. after a reset) and is dropped.
    assign rsp_fire         = sel_rvalid & (cnt_q != '0);
    assign sbr_rsp_rvalid_o = rsp_fire;
    assign sbr_rsp_rdata_o  = rsp_fire ? sel_rdata : '0;
    assign sbr_rsp_rid_o    = rsp_fire ? sel_rid   : '0;
    assign sbr_rsp_err_o    = rsp_fire & sel_err;

    // The error response always leaves the cycle after its grant and OBI has
    // no response back-pressure, so at most one aid is ever pending and a
    // single stage serves as the responder's aid queue.
    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q       <= '0;
            locked_q    <= '0;
            err_valid_q <= 1'b0;
            err_rid_q   <= '0;
            err_addr_q  <= '0;
        end else begin
            if (handshake) begin
                locked_q <= target;
            end
            if (handshake && !rsp_fire) begin
                cnt_q <= cnt_q + CntWidth'(1);
            end else if (!handshake && rsp_fire) begin
                cnt_q <= cnt_q - CntWidth'(1);
            end
            err_valid_q <= handshake & tgt_is_err;
            if (handshake && tgt_is_err) begin
                err_rid_q  <= sbr_req_aid_i;
                err_addr_q <= sbr_req_addr_i;
            end
        end
    end

    assign busy_o     = (cnt_q != '0);
    assign err_irq_o  = err_valid_q;
    assign err_addr_o = err_addr_q;

endmodule

// File: tb/tb_user_obi_demux.sv
// Self-checking bench for user_obi_demux (NumPorts=2, NumRules=2, NumMaxTrans=2).
// Inputs are driven on the falling edge and outputs sampled 1 ns later.
module tb_user_obi_demux;

    localparam int NP  = 2;
    localparam int NR  = 2;
    localparam int IDW = 4;
    localparam int TW  = 2;

    localparam logic [31:0] ErrData = 32'hBADCAB1E;
    localparam logic [31:0] Rdata0  = 32'hAAAA_0000;
    localparam logic [31:0] Rdata1  = 32'hBBBB_1111;

    logic                      clk;
    logic                      rst_n;
    logic [NR-1:0][TW-1:0]     map_idx;
    logic [NR-1:0][31:0]       map_start;
    logic [NR-1:0][31:0]       map_end;
    logic                      req, we;
    logic [3:0]                be;
    logic [31:0]               addr, wdata;
    logic [IDW-1:0]            aid;
    logic                      gnt, rvalid, err;
    logic [31:0]               rdata;
    logic [IDW-1:0]            rid;
    logic [NP-1:0]             m_req, m_we;
    logic [NP-1:0][3:0]        m_be;
    logic [NP-1:0][31:0]       m_addr, m_wdata;
    logic [NP-1:0][IDW-1:0]    m_aid;
    logic [NP-1:0]             m_gnt, m_rvalid, m_err;
    logic [NP-1:0][31:0]       m_rdata;
    logic [NP-1:0][IDW-1:0]    m_rid;
    logic                      busy, irq;
    logic [31:0]               err_addr;

    int n_vec = 0;
    int n_bad = 0;

    user_obi_demux #(
        .NumPorts    (NP),
        .NumRules    (NR),
        .NumMaxTrans (2),
        .ErrData     (ErrData),
        .IdWidth     (IDW)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .addr_map_idx_i   (map_idx),
        .addr_map_start_i (map_start),
        .addr_map_end_i   (map_end),
        .sbr_req_req_i    (req),
        .sbr_req_we_i     (we),
        .sbr_req_be_i     (be),
        .sbr_req_addr_i   (addr),
        .sbr_req_wdata_i  (wdata),
        .sbr_req_aid_i    (aid),
        .sbr_rsp_gnt_o    (gnt),
        .sbr_rsp_rvalid_o (rvalid),
        .sbr_rsp_rdata_o  (rdata),
        .sbr_rsp_rid_o    (rid),
        .sbr_rsp_err_o    (err),
        .mgr_req_req_o    (m_req),
        .mgr_req_we_o     (m_we),
        .mgr_req_be_o     (m_be),
        .mgr_req_addr_o   (m_addr),
        .mgr_req_wdata_o  (m_wdata),
        .mgr_req_aid_o    (m_aid),
        .mgr_rsp_gnt_i    (m_gnt),
        .mgr_rsp_rvalid_i (m_rvalid),
        .mgr_rsp_rdata_i  (m_rdata),
        .mgr_rsp_rid_i    (m_rid),
        .mgr_rsp_err_i    (m_err),
        .busy_o           (busy),
        .err_irq_o        (irq),
        .err_addr_o       (err_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  mgnt;      // port gnt inputs
        logic [1:0]  exp_mreq;  // expected per-port req
        logic        exp_gnt;   // expected upstream gnt
        int          tgt;       // expected target, 2 = error responder
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    // One request from idle; if granted, drain its response and return to idle.
    task automatic apply_vec(input vec_t v, input string tag);
        @(negedge clk);
        addr  = v.addr;
        m_gnt = v.mgnt;
        aid   = 4'h2;
        req   = 1'b1;
        #1;
        check({tag, " mreq"},  32'(m_req), 32'(v.exp_mreq));
        check({tag, " gnt"},   32'(gnt),   32'(v.exp_gnt));
        check({tag, " addr1"}, m_addr[1],  v.addr);
        @(negedge clk);
        req   = 1'b0;
        m_gnt = 2'b00;
        if (v.exp_gnt) begin
            if (v.tgt < NP) begin
                m_rvalid[v.tgt] = 1'b1;
                #1;
                check({tag, " rvalid"}, 32'(rvalid), 32'd1);
                check({tag, " rdata"},  rdata, (v.tgt == 0) ? Rdata0 : Rdata1);
            end else begin
                #1;
                check({tag, " err rvalid"}, 32'(rvalid), 32'd1);
                check({tag, " err rdata"},  rdata, ErrData);
                check({tag, " err irq"},    32'(irq), 32'd1);
                check({tag, " err addr"},   err_addr, v.addr);
            end
            @(negedge clk);
            m_rvalid = 2'b00;
        end
        #1;
        check({tag, " idle busy"}, 32'(busy),   32'd0);
        check({tag, " idle rv"},   32'(rvalid), 32'd0);
    endtask

    initial begin
        // rule0 [0x2000_0000,0x2000_1000)->0, rule1 [0x2000_1000,0x2000_2000)->1
        vecs = '{
            '{32'h2000_1004, 2'b10, 2'b10, 1'b1, 1},   // port 1, gnt passed through
            '{32'h2000_0000, 2'b01, 2'b01, 1'b1, 0},   // rule0 start inclusive
            '{32'h2000_0FFC, 2'b00, 2'b01, 1'b0, 0},   // port 0 not granting
            '{32'h2000_1000, 2'b11, 2'b10, 1'b1, 1},   // rule1 start inclusive
            '{32'h2000_2000, 2'b11, 2'b00, 1'b1, 2},   // rule1 end exclusive -> error
            '{32'h1FFF_FFFC, 2'b00, 2'b00, 1'b1, 2},   // below map -> error
            '{32'h2000_0FFF, 2'b10, 2'b01, 1'b0, 0}    // other port's gnt ignored
        };

        rst_n     = 1'b0;
        map_idx   = '{2'd1, 2'd0};
        map_start = '{32'h2000_1000, 32'h2000_0000};
        map_end   = '{32'h2000_2000, 32'h2000_1000};
        req = 1'b0; we = 1'b0; be = 4'hF; addr = '0; wdata = 32'h1234_5678; aid = '0;
        m_gnt = '0; m_rvalid = '0; m_err = '0;
        m_rdata = '{Rdata1, Rdata0};
        m_rid   = '{4'd9, 4'd1};

        // Reset state
        #12;
        check("rst gnt",    32'(gnt),    32'd0);
        check("rst rvalid", 32'(rvalid), 32'd0);
        check("rst rdata",  rdata,       32'd0);
        check("rst mreq",   32'(m_req),  32'd0);
        check("rst busy",   32'(busy),   32'd0);
        check("rst irq",    32'(irq),    32'd0);
        check("rst eaddr",  err_addr,    32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            apply_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Unmapped read with aid=5: response one cycle after grant
        @(negedge clk);
        addr = 32'h3000_0000; aid = 4'd5; req = 1'b1;
        #1;
        check("err gnt",  32'(gnt),   32'd1);
        check("err mreq", 32'(m_req), 32'd0);
        check("err rv early", 32'(rvalid), 32'd0);
        @(negedge clk);
        req = 1'b0;
        #1;
        check("err rvalid", 32'(rvalid), 32'd1);
        check("err rdata",  rdata,       ErrData);
        check("err err",    32'(err),    32'd1);
        check("err rid",    32'(rid),    32'd5);
        check("err irq",    32'(irq),    32'd1);
        check("err addr",   err_addr,    32'h3000_0000);
        @(negedge clk);
        #1;
        check("err irq off", 32'(irq),    32'd0);
        check("err rv off",  32'(rvalid), 32'd0);
        check("err busy",    32'(busy),   32'd0);

        // Back-to-back errors: one pulse per response, aids in order
        @(negedge clk);
        addr = 32'h3000_0100; aid = 4'd3; req = 1'b1;
        #1;
        check("b2b gnt0", 32'(gnt), 32'd1);
        @(negedge clk);
        addr = 32'h3000_0200; aid = 4'd7;
        #1;
        check("b2b gnt1", 32'(gnt),    32'd1);
        check("b2b rv0",  32'(rvalid), 32'd1);
        check("b2b rid0", 32'(rid),    32'd3);
        check("b2b irq0", 32'(irq),    32'd1);
        @(negedge clk);
        req = 1'b0;
        #1;
        check("b2b rv1",   32'(rvalid), 32'd1);
        check("b2b rid1",  32'(rid),    32'd7);
        check("b2b irq1",  32'(irq),    32'd1);
        check("b2b eaddr", err_addr,    32'h3000_0200);
        @(negedge clk);
        #1;
        check("b2b irq off", 32'(irq),  32'd0);
        check("b2b busy",    32'(busy), 32'd0);

        // Outstanding limit: three requests to a port that withholds rvalid
        @(negedge clk);
        addr = 32'h2000_0010; m_gnt = 2'b01; req = 1'b1;
        #1;
        check("max gnt0", 32'(gnt), 32'd1);
        @(negedge clk);
        #1;
        check("max gnt1",  32'(gnt),  32'd1);
        check("max busy1", 32'(busy), 32'd1);
        @(negedge clk);
        #1;
        check("max gnt2",  32'(gnt),   32'd0);
        check("max mreq2", 32'(m_req), 32'd0);
        check("max busy2", 32'(busy),  32'd1);
        @(negedge clk);
        #1;
        check("max gnt3", 32'(gnt), 32'd0);
        @(negedge clk);
        m_rvalid[0] = 1'b1;
        #1;
        check("max rv",    32'(rvalid), 32'd1);
        check("max rdata", rdata,       Rdata0);
        check("max gnt4",  32'(gnt),    32'd0);
        @(negedge clk);
        m_rvalid = 2'b00;
        #1;
        check("max gnt5",  32'(gnt),  32'd1);
        check("max busy5", 32'(busy), 32'd1);
        @(negedge clk);
        req = 1'b0; m_gnt = 2'b00; m_rvalid[0] = 1'b1;
        #1;
        check("max drain rv", 32'(rvalid), 32'd1);
        @(negedge clk);
        #1;
        check("max drain busy", 32'(busy), 32'd1);
        @(negedge clk);
        m_rvalid = 2'b00;
        #1;
        check("max idle", 32'(busy), 32'd0);

        // Target switch waits for the outstanding port-0 response
        @(negedge clk);
        addr = 32'h2000_0020; m_gnt = 2'b11; req = 1'b1;
        #1;
        check("lock gnt0", 32'(gnt), 32'd1);
        @(negedge clk);
        addr = 32'h2000_1020; m_rvalid[1] = 1'b1;
        #1;
        check("lock gnt1",  32'(gnt),    32'd0);
        check("lock mreq1", 32'(m_req),  32'd0);
        check("lock stale", 32'(rvalid), 32'd0);
        @(negedge clk);
        m_rvalid = 2'b01;
        #1;
        check("lock rv0",  32'(rvalid), 32'd1);
        check("lock gnt2", 32'(gnt),    32'd0);
        @(negedge clk);
        m_rvalid = 2'b00;
        #1;
        check("lock gnt3",  32'(gnt),   32'd1);
        check("lock mreq3", 32'(m_req), 32'd2);
        @(negedge clk);
        m_rvalid = 2'b10;
        #1;
        check("lock gnt+rv", 32'(gnt),    32'd1);
        check("lock rv1",    32'(rvalid), 32'd1);
        check("lock rid1",   32'(rid),    32'd9);
        @(negedge clk);
        req = 1'b0; m_rvalid = 2'b00; m_gnt = 2'b00;
        #1;
        check("lock cnt1 busy", 32'(busy), 32'd1);
        @(negedge clk);
        m_rvalid = 2'b10;
        #1;
        check("lock last rv", 32'(rvalid), 32'd1);
        @(negedge clk);
        m_rvalid = 2'b00;
        #1;
        check("lock idle", 32'(busy), 32'd0);

        // Asynchronous reset with two transactions outstanding
        @(negedge clk);
        addr = 32'h2000_0030; m_gnt = 2'b01; req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        req = 1'b0; m_gnt = 2'b00;
        #1;
        check("ar busy pre", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar busy",  32'(busy), 32'd0);
        check("ar eaddr", err_addr,  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        m_rvalid = 2'b01;
        #1;
        check("ar stale rv", 32'(rvalid), 32'd0);
        check("ar stale busy", 32'(busy), 32'd0);
        @(negedge clk);
        m_rvalid = 2'b00;

        // Overlapping rules: both cover 0x2000_0800, lowest-numbered wins
        map_idx   = '{2'd1, 2'd0};
        map_start = '{32'h2000_0000, 32'h2000_0800};
        map_end   = '{32'h2000_1000, 32'h2000_0900};
        apply_vec('{32'h2000_0800, 2'b11, 2'b01, 1'b1, 0}, "ovl hit");
        apply_vec('{32'h2000_0900, 2'b11, 2'b10, 1'b1, 1}, "ovl miss");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
